// File: rtl/handshake_alu_if.sv
// Operand/result handshake bundle for handshake_alu.
// The issuing stage drives the master side; the ALU sits on the slave side.
interface handshake_alu_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] data_in1;
  logic [WIDTH-1:0] data_in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             zero;
  logic             lt;
  logic             gt;
  logic             c_out;
  logic             overflow;

  modport master (
    output in_valid, alu_op, data_in1, data_in2, out_ready,
    input  in_ready, out_valid, data_out, zero, lt, gt, c_out, overflow
  );

  modport slave (
    input  in_valid, alu_op, data_in1, data_in2, out_ready,
    output in_ready, out_valid, data_out, zero, lt, gt, c_out, overflow
  );
endinterface

// File: rtl/handshake_alu.sv
// Registered ALU with valid/ready on both sides, a multi-cycle shift-add
// multiplier and arithmetic right shift. Result and flags hold until consumed.
module handshake_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  handshake_alu_if.slave   bus
);
  localparam int SHW  = $clog2(WIDTH);
  localparam int CNTW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_ADDU = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_SRA  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               zero_q, zero_d, lt_q, lt_d, gt_q, gt_d;
  logic               cout_q, cout_d, ovf_q, ovf_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic               mlt_q, mlt_d, mgt_q, mgt_d;

  logic               in_ready, out_valid;
  logic               accept, accept_mul, accept_alu, mul_last;
  logic [WIDTH-1:0]   a, b, b_eff, alu_res;
  logic [WIDTH:0]     sum;
  logic               carry_in, add_ovf, alu_cout, alu_ovf, op_lt, op_gt;
  logic [2*WIDTH-1:0] acc_step;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign accept     = bus.in_valid && in_ready;
  assign accept_mul = accept && (bus.alu_op == OP_MUL);
  assign accept_alu = accept && (bus.alu_op != OP_MUL);
  // The W-th shift-add step and the result capture share one edge.
  assign mul_last   = (state_q == S_MUL) && (cnt_q == CNTW'(WIDTH - 1));

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (accept)              state_d = accept_mul ? S_MUL : S_HOLD;
        else if (state_q == S_HOLD && bus.out_ready) state_d = S_IDLE;
      end
      S_MUL:   if (mul_last) state_d = S_HOLD;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE:  in_ready = 1'b1;
      S_HOLD: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready;
      end
      default: ;
    endcase
  end

  // Single adder serves ADD/ADDU/SUB; SUB is a + ~b + 1.
  always_comb begin
    a        = bus.data_in1;
    b        = bus.data_in2;
    carry_in = (bus.alu_op == OP_SUB);
    b_eff    = carry_in ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(carry_in);
    add_ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    op_lt    = $signed(a) < $signed(b);
    op_gt    = $signed(a) > $signed(b);
    alu_res  = sum[WIDTH-1:0];
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (bus.alu_op)
      OP_ADD, OP_SUB: begin
        alu_cout = sum[WIDTH];
        alu_ovf  = add_ovf;
      end
      OP_ADDU: begin
        alu_cout = sum[WIDTH];
        alu_ovf  = sum[WIDTH];
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, op_lt};
      OP_SRA:  alu_res = WIDTH'($signed(a) >>> b[SHW-1:0]);
      default: ;
    endcase
  end

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    data_d   = data_q;
    zero_d   = zero_q;
    lt_d     = lt_q;
    gt_d     = gt_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mlt_d    = mlt_q;
    mgt_d    = mgt_q;
    if (accept_alu) begin
      data_d = alu_res;
      zero_d = (alu_res == '0);
      lt_d   = op_lt;
      gt_d   = op_gt;
      cout_d = alu_cout;
      ovf_d  = alu_ovf;
    end
    if (accept_mul) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      mlt_d    = op_lt;
      mgt_d    = op_gt;
    end
    if (state_q == S_MUL) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNTW'(1);
      if (mul_last) begin
        data_d = acc_step[WIDTH-1:0];
        zero_d = (acc_step[WIDTH-1:0] == '0);
        lt_d   = mlt_q;
        gt_d   = mgt_q;
        cout_d = |acc_step[2*WIDTH-1:WIDTH];
        ovf_d  = |acc_step[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      zero_q   <= 1'b0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mlt_q    <= 1'b0;
      mgt_q    <= 1'b0;
    end else begin
      data_q   <= data_d;
      zero_q   <= zero_d;
      lt_q     <= lt_d;
      gt_q     <= gt_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mlt_q    <= mlt_d;
      mgt_q    <= mgt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.data_out  = data_q;
  assign bus.zero      = zero_q;
  assign bus.lt        = lt_q;
  assign bus.gt        = gt_q;
  assign bus.c_out     = cout_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_handshake_alu.sv
// Bench for handshake_alu: directed cases with literal expectations plus
// randomized traffic scored against an arithmetic reference model.
module tb_handshake_alu;
  localparam int W       = 16;
  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_AND  = 2;
  localparam int OP_OR   = 3;
  localparam int OP_SLT  = 4;
  localparam int OP_ADDU = 5;
  localparam int OP_MUL  = 6;
  localparam int OP_SRA  = 7;

  typedef struct {
    logic [15:0] data;
    logic        zero;
    logic        lt;
    logic        gt;
    logic        cout;
    logic        ovf;
    int          ready;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  handshake_alu_if #(.WIDTH(W)) bus ();
  handshake_alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_acc_cyc = 0;
  bit   chk_en     = 1'b0;
  bit   rand_ready = 1'b0;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model from the arithmetic definition of each opcode.
  function automatic exp_t model(input int op, input logic [15:0] a, input logic [15:0] b);
    exp_t   e;
    int     ua, ub, sa, sb, r, s;
    longint p;
    ua = a;  ub = b;
    sa = $signed(a);  sb = $signed(b);
    e.cout = 1'b0;  e.ovf = 1'b0;  e.ready = 0;
    r = 0;
    case (op)
      OP_ADD, OP_ADDU: begin
        r = ua + ub;
        e.cout = (r > 65535);
        s = sa + sb;
        e.ovf = (op == OP_ADDU) ? e.cout : (s > 32767 || s < -32768);
      end
      OP_SUB: begin
        r = ua + ((~ub) & 32'hFFFF) + 1;
        e.cout = (r > 65535);
        s = sa - sb;
        e.ovf = (s > 32767 || s < -32768);
      end
      OP_AND: r = ua & ub;
      OP_OR:  r = ua | ub;
      OP_SLT: r = (sa < sb) ? 1 : 0;
      OP_MUL: begin
        p = longint'(ua) * longint'(ub);
        r = int'(p & 64'hFFFF);
        e.cout = ((p >> 16) != 0);
        e.ovf  = e.cout;
      end
      default: r = sa >>> (ub % 16);
    endcase
    e.data = r[15:0];
    e.zero = (e.data == 16'h0);
    e.lt   = (sa < sb);
    e.gt   = (sa > sb);
    return e;
  endfunction

  // Scoreboard: every cycle, the DUT must match what the queued work implies.
  always @(negedge clk) begin
    if (chk_en) begin
      if (q.size() == 0) begin
        check("out_valid_idle", 32'(bus.out_valid), 32'd0);
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
      end else if (cyc < q[0].ready) begin
        check("out_valid_early", 32'(bus.out_valid), 32'd0);
        check("in_ready_busy", 32'(bus.in_ready), 32'd0);
      end else begin
        check("out_valid_due", 32'(bus.out_valid), 32'd1);
        check("in_ready_hold", 32'(bus.in_ready), 32'(bus.out_ready));
        if (bus.out_valid) begin
          check("data_out", 32'(bus.data_out), 32'(q[0].data));
          check("zero", 32'(bus.zero), 32'(q[0].zero));
          check("lt", 32'(bus.lt), 32'(q[0].lt));
          check("gt", 32'(bus.gt), 32'(q[0].gt));
          check("c_out", 32'(bus.c_out), 32'(q[0].cout));
          check("overflow", 32'(bus.overflow), 32'(q[0].ovf));
          if (bus.out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present one op and hold it until accepted; returns just after the accept edge.
  task automatic issue(input int op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   budget;
    bus.in_valid = 1'b1;
    bus.alu_op   = 3'(op);
    bus.data_in1 = a;
    bus.data_in2 = b;
    budget = 200;
    do begin
      @(negedge clk);
      budget--;
    end while (!bus.in_ready && budget > 0);
    check("issue_accepted", 32'(bus.in_ready), 32'd1);
    if (bus.in_ready) begin
      last_acc_cyc = cyc;
      e = model(op, a, b);
      e.ready = cyc + 1 + ((op == OP_MUL) ? W : 0);
      sync();
      q.push_back(e);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    int budget;
    budget = 100;
    do begin
      @(negedge clk);
      budget--;
    end while (!bus.out_valid && budget > 0);
    check("wait_valid", 32'(bus.out_valid), 32'd1);
    lat = cyc - last_acc_cyc;
  endtask

  function automatic logic [15:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    exp_t m;
    int   lat, c0, prev, op, budget;
    logic [15:0] ra, rb;

    bus.in_valid  = 1'b0;
    bus.alu_op    = 3'd0;
    bus.data_in1  = '0;
    bus.data_in2  = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_flags", 32'({bus.zero, bus.lt, bus.gt, bus.c_out, bus.overflow}), 32'd0);
    sync();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    sync();

    // Pin the model to hand-computed values.
    m = model(OP_ADD, 16'h4491, 16'h44B1);
    check("model_add", 32'({m.data, m.ovf, m.cout, m.lt, m.gt, m.zero}), 32'({16'h8942, 5'b10100}));
    m = model(OP_SUB, 16'h4417, 16'h84B1);
    check("model_sub", 32'({m.data, m.ovf, m.cout, m.gt}), 32'({16'hBF66, 3'b101}));
    m = model(OP_MUL, 16'h0123, 16'h0045);
    check("model_mul", 32'({m.data, m.cout}), 32'({16'h4E6F, 1'b0}));
    m = model(OP_SRA, 16'h8000, 16'h0013);
    check("model_sra", 32'(m.data), 32'hF000);

    // ADD.
    issue(OP_ADD, 16'h4491, 16'h44B1);
    wait_valid(lat);
    check("add_latency", 32'(lat), 32'd1);
    check("add_data", 32'(bus.data_out), 32'h8942);
    check("add_flags", 32'({bus.overflow, bus.c_out, bus.lt, bus.gt, bus.zero}), 32'b10100);
    sync();

    // SUB, then equal operands.
    issue(OP_SUB, 16'h4417, 16'h84B1);
    wait_valid(lat);
    check("sub_data", 32'(bus.data_out), 32'hBF66);
    check("sub_flags", 32'({bus.overflow, bus.c_out, bus.gt}), 32'b101);
    sync();
    issue(OP_SUB, 16'h1234, 16'h1234);
    wait_valid(lat);
    check("sub_eq_data", 32'(bus.data_out), 32'h0000);
    check("sub_eq_flags", 32'({bus.zero, bus.lt, bus.gt, bus.c_out}), 32'b1001);
    sync();

    // MUL.
    issue(OP_MUL, 16'h0123, 16'h0045);
    wait_valid(lat);
    check("mul_latency", 32'(lat), 32'd17);
    check("mul_data", 32'(bus.data_out), 32'h4E6F);
    check("mul_cout", 32'(bus.c_out), 32'd0);
    sync();
    issue(OP_MUL, 16'h1000, 16'h0010);
    wait_valid(lat);
    check("mul_wrap_data", 32'(bus.data_out), 32'h0000);
    check("mul_wrap_flags", 32'({bus.zero, bus.c_out, bus.overflow}), 32'b111);
    sync();

    // SLT and SRA.
    issue(OP_SLT, 16'hFFFF, 16'h0001);
    wait_valid(lat);
    check("slt_data", 32'(bus.data_out), 32'h0001);
    check("slt_lt", 32'(bus.lt), 32'd1);
    sync();
    issue(OP_SRA, 16'h8000, 16'h0013);
    wait_valid(lat);
    check("sra_data", 32'(bus.data_out), 32'hF000);
    sync();

    // Backpressure, then a back-to-back accept on release.
    bus.out_ready = 1'b0;
    issue(OP_ADD, 16'h4491, 16'h44B1);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      check("bp_data", 32'(bus.data_out), 32'h8942);
      check("bp_flags", 32'({bus.overflow, bus.c_out, bus.lt}), 32'b101);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    sync();
    bus.out_ready = 1'b1;
    c0 = cyc;
    issue(OP_OR, 16'h0491, 16'h04B1);
    check("bp_same_cycle_accept", 32'(last_acc_cyc), 32'(c0));
    wait_valid(lat);
    check("or_data", 32'(bus.data_out), 32'h04B1);
    sync();

    // Back-to-back throughput: one op per cycle.
    issue(OP_ADD, 16'h0001, 16'h0002);
    prev = last_acc_cyc;
    for (int i = 0; i < 3; i++) begin
      issue(OP_AND, 16'($urandom), 16'($urandom));
      check("b2b_spacing", 32'(last_acc_cyc - prev), 32'd1);
      prev = last_acc_cyc;
    end
    wait_valid(lat);
    sync();
    sync();

    // Reset in the middle of a multiply.
    issue(OP_MUL, 16'h0123, 16'h0045);
    repeat (5) @(negedge clk);
    #1;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    q.delete();
    #1;
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_data", 32'(bus.data_out), 32'd0);
    check("mrst_flags", 32'({bus.zero, bus.lt, bus.gt, bus.c_out, bus.overflow}), 32'd0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mrst_no_pulse", 32'(bus.out_valid), 32'd0);
    sync();
    chk_en = 1'b1;
    issue(OP_ADDU, 16'hFFFF, 16'h0002);
    wait_valid(lat);
    check("addu_data", 32'(bus.data_out), 32'h0001);
    check("addu_flags", 32'({bus.c_out, bus.overflow}), 32'b11);
    sync();

    // Randomized traffic with random backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      repeat ($urandom_range(0, 2)) sync();
      op = $urandom_range(0, 7);
      if (op == OP_MUL && $urandom_range(0, 3) != 0) op = OP_SUB;
      ra = rnd_operand();
      rb = ($urandom_range(0, 7) == 0) ? ra : rnd_operand();
      issue(op, ra, rb);
    end

    // Drain.
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;
    budget = 200;
    while (q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
    sync();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
